multdiv_iter: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit: the responder side of the processor's

---
 rtl/multdiv_iter_if.sv | 23 ++
 rtl/multdiv_iter.sv | 157 +++++++++++++++
 tb/tb_multdiv_iter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_iter_if.sv
// Operand/control/result bundle between the execute stage (master) and the
// iterative multiply/divide unit (slave).
interface multdiv_iter_if #(
    parameter int WIDTH = 32
);
    logic signed [WIDTH-1:0] data_operandA;
    logic signed [WIDTH-1:0] data_operandB;
    logic                    ctrl_MULT;
    logic                    ctrl_DIV;
    logic signed [WIDTH-1:0] data_result;
    logic                    data_exception;
    logic                    data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide, one bit per cycle on operand magnitudes.
// Optional MULTDIV_DIV0_FAST_EN: divide-by-zero completes one cycle after start.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    typedef struct packed {
        logic signed [WIDTH-1:0] result;
        logic                    exc;
    } res_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            start_mult, start_div, b_zero, fast_div0;
    logic            load, step, finish;
    res_t            fin;

    logic [WIDTH-1:0] hi, lo, b_mag;
    logic             is_div, neg, div0;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic signed [WIDTH-1:0] result_q;
    logic                    exc_q, rdy_q;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    // Sign reapplied to the full product; overflow if the top WIDTH+1 bits disagree.
    function automatic res_t mult_finish(input logic [2*WIDTH-1:0] p, input logic n);
        logic [2*WIDTH-1:0] s;
        logic [WIDTH:0]     upper;
        res_t               r;
        s        = n ? (~p + (2*WIDTH)'(1)) : p;
        upper    = s[2*WIDTH-1:WIDTH-1];
        r.result = s[WIDTH-1:0];
        r.exc    = !((&upper) || !(|upper));
        return r;
    endfunction

    // A positive quotient with the MSB set only arises from INT_MIN / -1.
    function automatic res_t div_finish(input logic [WIDTH-1:0] q, input logic n,
                                        input logic dz);
        res_t r;
        if (dz) begin
            r.result = '0;
            r.exc    = 1'b1;
        end else begin
            r.result = n ? (~q + WIDTH'(1)) : q;
            r.exc    = !n && q[WIDTH-1];
        end
        return r;
    endfunction

    assign start_mult = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign b_zero     = (bus.data_operandB == '0);

`ifdef MULTDIV_DIV0_FAST_EN
    assign fast_div0 = b_zero;
`else
    assign fast_div0 = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                count <= '0;
            else if (step)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_mult)
            state_nxt = MULT;
        else if (start_div)
            state_nxt = fast_div0 ? DONE : DIV;
        else begin
            unique case (state)
                MULT, DIV: if (count == LAST) state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        load   = start_mult | start_div;
        step   = !load && (state == MULT || state == DIV);
        finish = (state == DONE);
        fin    = is_div ? div_finish(lo, neg, div0) : mult_finish({hi, lo}, neg);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] shifted;
        logic           ok;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ok      = shifted >= {1'b0, b_mag};
        if (is_div) begin
            hi_nxt = ok ? (shifted[WIDTH-1:0] - b_mag) : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ok};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            is_div <= start_div;
            neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            div0   <= b_zero;
            b_mag  <= magnitude(bus.data_operandB);
            lo     <= magnitude(bus.data_operandA);
            hi     <= '0;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= finish;
            if (finish) begin
                result_q <= fin.result;
                exc_q    <= fin.exc;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed vector bench for multdiv_iter: result values, latency, restart,
// simultaneous-start rejection and mid-operation reset.
module tb_multdiv_iter;
    localparam int W   = 32;
    localparam int LAT = W + 1;
`ifdef MULTDIV_DIV0_FAST_EN
    localparam int LAT_DZ = 1;
`else
    localparam int LAT_DZ = W + 1;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multdiv_iter_if #(.WIDTH(W)) bus ();
    multdiv_iter #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start pulse lands on the next rising edge; operands are scrambled right after it.
    task automatic start_op(input bit d, input logic [31:0] a, input logic [31:0] b,
                            input bit both);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = both | ~d;
        bus.ctrl_DIV      = both | d;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = ~b;
    endtask

    task automatic wait_rdy(input int limit, output int n, output bit held);
        logic [31:0] prev_res;
        logic        prev_exc;
        prev_res = bus.data_result;
        prev_exc = bus.data_exception;
        held     = 1'b1;
        n        = 0;
        while (n < limit) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.data_resultRDY) return;
            if (bus.data_result !== prev_res || bus.data_exception !== prev_exc) held = 1'b0;
        end
        n = -1;
    endtask

    task automatic watch_no_rdy(input int cycles, output bit seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) seen = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  held, seen;

        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, LAT};
        vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, LAT};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, LAT};
        vecs[3]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, LAT};
        vecs[5]  = '{1'b0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, LAT};
        vecs[6]  = '{1'b1, 32'hFFFF_FFD5, 32'h0000_0005, 32'hFFFF_FFF8, 1'b0, LAT};
        vecs[7]  = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, LAT};
        vecs[8]  = '{1'b1, 32'h0000_0064, 32'h0000_0000, 32'h0000_0000, 1'b1, LAT_DZ};
        vecs[9]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, LAT};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, LAT};

        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exc", {31'b0, bus.data_exception}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].is_div, vecs[i].a, vecs[i].b, 1'b0);
            wait_rdy(80, n, held);
            check($sformatf("v%0d_latency", i), n, vecs[i].lat);
            check($sformatf("v%0d_result", i), bus.data_result, vecs[i].res);
            check($sformatf("v%0d_exc", i), {31'b0, bus.data_exception}, {31'b0, vecs[i].exc});
            check($sformatf("v%0d_hold_while_busy", i), {31'b0, held}, 32'd1);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_rdy_one_cycle", i), {31'b0, bus.data_resultRDY}, 32'd0);
        end

        // Restart: MULT 3x3 at edge 0 is discarded by DIV 9/3 at edge 10.
        start_op(1'b0, 32'd3, 32'd3, 1'b0);
        watch_no_rdy(9, seen);
        start_op(1'b1, 32'd9, 32'd3, 1'b0);
        check("restart_no_early_rdy", {31'b0, seen}, 32'd0);
        wait_rdy(80, n, held);
        check("restart_latency", n, LAT);
        check("restart_result", bus.data_result, 32'd3);
        check("restart_exc", {31'b0, bus.data_exception}, 32'd0);

        // Both starts together are ignored.
        repeat (2) @(posedge clock);
        start_op(1'b0, 32'd4, 32'd4, 1'b1);
        watch_no_rdy(45, seen);
        check("both_start_no_rdy", {31'b0, seen}, 32'd0);
        check("both_start_result_held", bus.data_result, 32'd3);

        // Reset at edge 15 aborts MULT 5x5 started at edge 0.
        start_op(1'b0, 32'd5, 32'd5, 1'b0);
        watch_no_rdy(14, seen);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_result_cleared", bus.data_result, 32'd0);
        check("abort_exc_cleared", {31'b0, bus.data_exception}, 32'd0);
        watch_no_rdy(40, held);
        check("abort_no_rdy", {31'b0, seen | held}, 32'd0);
        check("abort_result_stays0", bus.data_result, 32'd0);

        start_op(1'b0, 32'd5, 32'd5, 1'b0);
        wait_rdy(80, n, held);
        check("fresh_latency", n, LAT);
        check("fresh_result", bus.data_result, 32'd25);
        check("fresh_exc", {31'b0, bus.data_exception}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
